apb_master_fsm: RTL and testbench
=================================

Name: apb_master_fsm

Overview:
APB-clock-domain stage of the AXI-to-APB bridge. It pops packed request entries from the top (AXI-to-APB) async FIFO and splits them into fields. It runs one APB4 transfer per entry and pushes one response entry per transfer into the bottom (APB-to-AXI) async FIFO. Exactly one transfer is in flight at a time.

Parameters:
DATASIZE, 32, APB data width; must be a multiple of 8
ADDRSIZE, 32, APB address width
TOP_FIFO_DATA_SIZE, DATASIZE+ADDRSIZE+4+DATASIZE/8, request entry width
BOT_FIFO_DATA_SIZE, DATASIZE+2, response entry width
TIMEOUT, 256, maximum ACCESS cycles before forced error; 0 disables the timeout

Ports:
APB_clk  in  1  APB clock
APB_rst_n  in  1  asynchronous active-low reset
rdata_top  in  TOP_FIFO_DATA_SIZE  top FIFO head, first-word-fall-through; valid while rempty_top=0
rempty_top  in  1  top FIFO empty
rinc_top  out  1  top FIFO pop, one-cycle pulse
wfull_bottom  in  1  bottom FIFO full
winc_bottom  out  1  bottom FIFO push, one-cycle pulse
wdata_bottom  out  BOT_FIFO_DATA_SIZE  response entry {prdata, pslverr, write_read}
PSEL, PENABLE, PWRITE  out  1 each  APB control
PADDR  out  ADDRSIZE  APB address
PWDATA  out  DATASIZE  APB write data
PSTRB  out  DATASIZE/8  APB write strobes
PPROT  out  3  APB protection
PRDATA  in  DATASIZE  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Request entry layout, LSB first:
  - bit0: write_read (1 = write)
  - [ADDRSIZE:1]: address
  - next 3 bits: pprot
  - next DATASIZE/8 bits: strobe
  - top DATASIZE bits: write data
- Reset (async, APB_rst_n=0): state=IDLE; all P* outputs, rinc_top, winc_bottom, the wdata_bottom register fields and the timeout counter go to 0. Asserting reset mid-transfer aborts it with no response pushed; a partly popped entry is lost.
- IDLE:
  - Start condition: rempty_top=0 AND wfull_bottom=0. On start, rinc_top=1 for that cycle (combinational), all fields of rdata_top are captured into registers, next state=SETUP.
  - Otherwise rinc_top=0 and state holds.
  - Checking wfull_bottom before the pop reserves a response slot, so the push never stalls.
- SETUP: PSEL=1, PENABLE=0; address/control/data are driven from the captured registers; next state=ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1. Timeout counter increments each cycle PREADY=0.
  - PREADY=1: winc_bottom=1 for that cycle. wdata_bottom = {PRDATA if read else 0, PSLVERR, write_read}. Counter clears. Next state=IDLE.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 with PREADY=0: the transfer terminates with winc_bottom=1 and wdata_bottom = {0, 1, write_read}; next state=IDLE.
  - PREADY arriving on the same cycle as timeout expiry wins: the normal response is pushed.
- P* outputs are registered and stable from SETUP through the final ACCESS cycle.
- In IDLE: PSEL=PENABLE=0; PADDR/PWRITE/PPROT/PWDATA/PSTRB hold their last values.
- PSTRB is forced to 0 for reads (APB4 rule); PWDATA is don't-care for reads but is driven from the entry.
- Throughput: minimum 3 APB_clk per transfer (IDLE, SETUP, ACCESS); no back-to-back SETUP.
- wdata_bottom and winc_bottom are valid only in the push cycle.
- No new pop while a transfer is in flight; top FIFO backpressure is implicit.

Test Plan:
- Write entry {32'hDEADBEEF, 4'hF, 3'b010, 32'h4000_0010, 1'b1}, PREADY=1 in first ACCESS -> one rinc_top pulse. SETUP cycle: PADDR=0x40000010, PWRITE=1, PWDATA=0xDEADBEEF, PSTRB=0xF, PPROT=2. One cycle later winc_bottom=1 with wdata_bottom={0, 0, 1}.
- Read addr 0x4000_0020, strobe field 0xF, PRDATA=0x12345678, PREADY delayed 3 cycles -> PSTRB=0, PENABLE high for 4 cycles, wdata_bottom={0x12345678, 0, 0}.
- Read with PSLVERR=1 on the PREADY cycle -> wdata_bottom={PRDATA, 1, 0}; the next entry is processed normally.
- TIMEOUT=4, PREADY held 0 -> exactly 4 ACCESS cycles, then a push of {0, 1, write_read} and return to IDLE.
- wfull_bottom=1 with rempty_top=0 -> no rinc_top, PSEL stays 0. Deasserting wfull_bottom -> pop on that same cycle.
- Reset asserted during ACCESS -> all outputs 0 immediately, no winc_bottom. After release, the next FIFO entry starts from IDLE.

Source files
------------

// File: rtl/apb_master_fsm.sv
// APB-side stage of the AXI-to-APB bridge: pops one request entry from the top
// async FIFO, runs a single APB4 transfer and pushes one response entry into
// the bottom async FIFO.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for a request and a free response slot; pops on start
// SETUP  | APB setup phase (PSEL=1, PENABLE=0) from the captured entry
// ACCESS | APB access phase; waits for PREADY or the timeout, then pushes
module apb_master_fsm #(
  parameter int DATASIZE           = 32,
  parameter int ADDRSIZE           = 32,
  parameter int TOP_FIFO_DATA_SIZE = DATASIZE + ADDRSIZE + 4 + DATASIZE / 8,
  parameter int BOT_FIFO_DATA_SIZE = DATASIZE + 2,
  parameter int TIMEOUT            = 256
) (
  input  logic                          APB_clk,
  input  logic                          APB_rst_n,
  input  logic [TOP_FIFO_DATA_SIZE-1:0] rdata_top,
  input  logic                          rempty_top,
  output logic                          rinc_top,
  input  logic                          wfull_bottom,
  output logic                          winc_bottom,
  output logic [BOT_FIFO_DATA_SIZE-1:0] wdata_bottom,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDRSIZE-1:0]           PADDR,
  output logic [DATASIZE-1:0]           PWDATA,
  output logic [DATASIZE/8-1:0]         PSTRB,
  output logic [2:0]                    PPROT,
  input  logic [DATASIZE-1:0]           PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int STRB_W   = DATASIZE / 8;
  localparam int PROT_LSB = ADDRSIZE + 1;
  localparam int STRB_LSB = ADDRSIZE + 4;
  localparam int DATA_LSB = ADDRSIZE + 4 + STRB_W;
  localparam int TCW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TCW-1:0] TC_LAST = TCW'(TLAST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDRSIZE-1:0]   paddr_q, paddr_d;
  logic [DATASIZE-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic [2:0]            pprot_q, pprot_d;
  logic [TCW-1:0]        cnt_q, cnt_d;

  logic                  pop;
  logic                  push;
  logic                  resp_err;
  logic [DATASIZE-1:0]   resp_data;

  // Next-state, captured request fields, timeout counting and response build.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    push      = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state_q)
      IDLE: begin
        // Requiring a free response slot before popping means the push
        // at the end of the transfer can never be blocked.
        if (!rempty_top && !wfull_bottom) begin
          pop       = 1'b1;
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = rdata_top[0];
          paddr_d   = rdata_top[ADDRSIZE:1];
          pprot_d   = rdata_top[PROT_LSB +: 3];
          pstrb_d   = rdata_top[0] ? rdata_top[STRB_LSB +: STRB_W] : '0;
          pwdata_d  = rdata_top[DATA_LSB +: DATASIZE];
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the expiry cycle wins.
        if (PREADY) begin
          push      = 1'b1;
          resp_err  = PSLVERR;
          resp_data = pwrite_q ? '0 : PRDATA;
          cnt_d     = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (TIMEOUT != 0 && cnt_q == TC_LAST) begin
          push      = 1'b1;
          resp_err  = 1'b1;
          cnt_d     = '0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State and registered APB outputs; reset aborts any transfer in flight.
  always_ff @(posedge APB_clk or negedge APB_rst_n) begin
    if (!APB_rst_n) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      cnt_q     <= cnt_d;
    end
  end

  // Pop is gated by reset so a held reset never drains the request FIFO.
  assign rinc_top     = pop & APB_rst_n;
  assign winc_bottom  = push;
  assign wdata_bottom = push ? {resp_data, resp_err, pwrite_q} : '0;

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PPROT   = pprot_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: a cycle-by-cycle vector table for the
// write/read/error flows plus hand sequences for timeout, full FIFO and reset.
module tb_apb_master_fsm;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = DW + AW + 4 + DW / 8;
  localparam int BW = DW + 2;
  localparam int OW = 1 + 1 + BW + 3 + AW + DW + DW / 8 + 3;

  logic            APB_clk = 1'b0;
  logic            APB_rst_n;
  logic [TW-1:0]   rdata_top;
  logic            rempty_top;
  logic            rinc_top;
  logic            wfull_bottom;
  logic            winc_bottom;
  logic [BW-1:0]   wdata_bottom;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]      PPROT;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;
  logic            PSLVERR;

  apb_master_fsm #(
    .DATASIZE(DW), .ADDRSIZE(AW), .TIMEOUT(4)
  ) dut (
    .APB_clk(APB_clk), .APB_rst_n(APB_rst_n),
    .rdata_top(rdata_top), .rempty_top(rempty_top), .rinc_top(rinc_top),
    .wfull_bottom(wfull_bottom), .winc_bottom(winc_bottom),
    .wdata_bottom(wdata_bottom),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 APB_clk = ~APB_clk;

  typedef struct {
    logic          rempty;
    logic          wfull;
    logic [TW-1:0] rdata;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] outs();
    return {rinc_top, winc_bottom, wdata_bottom, PSEL, PENABLE, PWRITE,
            PADDR, PWDATA, PSTRB, PPROT};
  endfunction

  function automatic logic [OW-1:0] expo(input logic rinc, input logic winc,
      input logic [BW-1:0] wd, input logic psel, input logic pen, input logic pwr,
      input logic [AW-1:0] pa, input logic [DW-1:0] pwd, input logic [3:0] ps,
      input logic [2:0] pp);
    return {rinc, winc, wd, psel, pen, pwr, pa, pwd, ps, pp};
  endfunction

  function automatic logic [TW-1:0] ent(input logic [31:0] wd, input logic [3:0] st,
      input logic [2:0] pr, input logic [31:0] ad, input logic wr);
    return {wd, st, pr, ad, wr};
  endfunction

  task automatic cyc();
    @(posedge APB_clk);
    #1;
  endtask

  logic [TW-1:0] e1, e2, e3, e4, e5, e6, e7, e8;
  logic [BW-1:0] wd_seen;
  int            acc_cycles;
  logic          pushed;

  initial begin
    e1 = ent(32'hDEADBEEF, 4'hF, 3'b010, 32'h4000_0010, 1'b1);
    e2 = ent(32'hCAFEF00D, 4'hF, 3'b000, 32'h4000_0020, 1'b0);
    e3 = ent(32'h0000_0000, 4'h3, 3'b101, 32'h4000_0030, 1'b0);
    e4 = ent(32'h1122_3344, 4'h3, 3'b001, 32'h4000_0040, 1'b1);
    e5 = ent(32'h0000_0055, 4'h1, 3'b000, 32'h5000_0050, 1'b1);
    e6 = ent(32'h0000_0077, 4'hF, 3'b011, 32'h6000_0060, 1'b0);
    e7 = ent(32'h0000_0099, 4'h8, 3'b111, 32'h7000_0070, 1'b1);
    e8 = ent(32'h0000_00AA, 4'h0, 3'b000, 32'h8000_0080, 1'b0);

    vecs[0]  = '{1'b0, 1'b0, e1, 1'b0, 1'b0, 32'h0,
                 expo(1, 0, '0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 3'd0)};
    vecs[1]  = '{1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h0,
                 expo(0, 0, '0, 1, 0, 1, 32'h4000_0010, 32'hDEADBEEF, 4'hF, 3'd2)};
    vecs[2]  = '{1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h0BAD_0BAD,
                 expo(0, 1, 34'h1, 1, 1, 1, 32'h4000_0010, 32'hDEADBEEF, 4'hF, 3'd2)};
    vecs[3]  = '{1'b0, 1'b0, e2, 1'b0, 1'b0, 32'h0,
                 expo(1, 0, '0, 0, 0, 1, 32'h4000_0010, 32'hDEADBEEF, 4'hF, 3'd2)};
    vecs[4]  = '{1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h0,
                 expo(0, 0, '0, 1, 0, 0, 32'h4000_0020, 32'hCAFEF00D, 4'h0, 3'd0)};
    vecs[5]  = '{1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h1234_5678,
                 expo(0, 0, '0, 1, 1, 0, 32'h4000_0020, 32'hCAFEF00D, 4'h0, 3'd0)};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = '{1'b1, 1'b0, '0, 1'b1, 1'b0, 32'h1234_5678,
                 expo(0, 1, 34'h0_48D1_59E0, 1, 1, 0, 32'h4000_0020, 32'hCAFEF00D, 4'h0, 3'd0)};
    vecs[9]  = '{1'b0, 1'b0, e3, 1'b0, 1'b0, 32'h0,
                 expo(1, 0, '0, 0, 0, 0, 32'h4000_0020, 32'hCAFEF00D, 4'h0, 3'd0)};
    vecs[10] = '{1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h0,
                 expo(0, 0, '0, 1, 0, 0, 32'h4000_0030, 32'h0, 4'h0, 3'd5)};
    vecs[11] = '{1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hA5A5_A5A5,
                 expo(0, 1, 34'h2_9696_9696, 1, 1, 0, 32'h4000_0030, 32'h0, 4'h0, 3'd5)};
    vecs[12] = '{1'b0, 1'b0, e4, 1'b0, 1'b0, 32'h0,
                 expo(1, 0, '0, 0, 0, 0, 32'h4000_0030, 32'h0, 4'h0, 3'd5)};
    vecs[13] = '{1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h0,
                 expo(0, 0, '0, 1, 0, 1, 32'h4000_0040, 32'h1122_3344, 4'h3, 3'd1)};
    vecs[14] = '{1'b1, 1'b0, '0, 1'b1, 1'b0, 32'hFFFF_FFFF,
                 expo(0, 1, 34'h1, 1, 1, 1, 32'h4000_0040, 32'h1122_3344, 4'h3, 3'd1)};
    vecs[15] = '{1'b1, 1'b0, '0, 1'b0, 1'b0, 32'h0,
                 expo(0, 0, '0, 0, 0, 1, 32'h4000_0040, 32'h1122_3344, 4'h3, 3'd1)};

    APB_rst_n    = 1'b0;
    rdata_top    = '0;
    rempty_top   = 1'b1;
    wfull_bottom = 1'b0;
    PRDATA       = '0;
    PREADY       = 1'b0;
    PSLVERR      = 1'b0;
    repeat (2) @(posedge APB_clk);
    #1;
    check("reset_state", 128'(outs()), 128'(0));
    APB_rst_n = 1'b1;

    // Table: write, delayed read (PREADY on the timeout cycle), error read, write.
    for (int i = 0; i < 16; i++) begin
      rempty_top   = vecs[i].rempty;
      wfull_bottom = vecs[i].wfull;
      rdata_top    = vecs[i].rdata;
      PREADY       = vecs[i].pready;
      PSLVERR      = vecs[i].pslverr;
      PRDATA       = vecs[i].prdata;
      #1;
      check($sformatf("vec%0d", i), 128'(outs()), 128'(vecs[i].exp));
      cyc();
    end

    // Timeout: PREADY never arrives.
    rempty_top = 1'b0;
    rdata_top  = e5;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    PRDATA     = 32'hFFFF_FFFF;
    #1;
    check("to_pop", 128'(rinc_top), 128'(1));
    cyc();
    rempty_top = 1'b1;
    #1;
    check("to_setup", 128'({PSEL, PENABLE, PADDR}), 128'({2'b10, 32'h5000_0050}));
    cyc();
    acc_cycles = 0;
    pushed     = 1'b0;
    wd_seen    = '0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (PSEL && PENABLE) acc_cycles++;
      if (winc_bottom) begin
        pushed  = 1'b1;
        wd_seen = wdata_bottom;
        break;
      end
      cyc();
    end
    check("to_pushed", 128'(pushed), 128'(1));
    check("to_access_cycles", 128'(acc_cycles), 128'(4));
    check("to_resp", 128'(wd_seen), 128'(34'h3));
    cyc();
    check("to_idle", 128'({PSEL, PENABLE, winc_bottom}), 128'(0));

    // Response FIFO full blocks the pop; release pops on the same cycle.
    rempty_top   = 1'b0;
    wfull_bottom = 1'b1;
    rdata_top    = e6;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("full_hold%0d", k), 128'({rinc_top, PSEL}), 128'(0));
      cyc();
    end
    wfull_bottom = 1'b0;
    #1;
    check("full_release_pop", 128'(rinc_top), 128'(1));
    cyc();
    rempty_top = 1'b1;
    #1;
    check("full_setup", 128'({PSEL, PENABLE, PWRITE, PADDR, PSTRB, PPROT}),
          128'({3'b100, 32'h6000_0060, 4'h0, 3'd3}));
    cyc();
    PREADY = 1'b1;
    PRDATA = 32'h0000_BEEF;
    #1;
    check("full_resp", 128'({winc_bottom, wdata_bottom}), 128'({1'b1, 34'h2FBBC}));
    cyc();
    PREADY = 1'b0;

    // Reset during ACCESS aborts the transfer without a push.
    rempty_top = 1'b0;
    rdata_top  = e7;
    #1;
    check("rst_pop", 128'(rinc_top), 128'(1));
    cyc();
    rempty_top = 1'b1;
    cyc();
    check("rst_in_access", 128'({PSEL, PENABLE, PADDR}), 128'({2'b11, 32'h7000_0070}));
    rempty_top = 1'b0;
    rdata_top  = e8;
    PREADY     = 1'b1;
    PRDATA     = 32'h1234_0000;
    APB_rst_n  = 1'b0;
    #1;
    check("rst_abort", 128'(outs()), 128'(0));
    @(posedge APB_clk);
    #1;
    check("rst_hold", 128'(outs()), 128'(0));
    PREADY    = 1'b0;
    APB_rst_n = 1'b1;
    #1;
    check("post_rst_pop", 128'(rinc_top), 128'(1));
    cyc();
    rempty_top = 1'b1;
    #1;
    check("post_rst_setup", 128'({PSEL, PENABLE, PWRITE, PADDR}),
          128'({3'b100, 32'h8000_0080}));
    cyc();
    PREADY = 1'b1;
    PRDATA = 32'h0000_0001;
    #1;
    check("post_rst_resp", 128'({winc_bottom, wdata_bottom}), 128'({1'b1, 34'h4}));
    cyc();
    PREADY = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
